bldc_commutator: RTL and testbench
==================================

Name: bldc_commutator

Overview:
- Upstream control stage for three Phase_Driver instances, one per motor phase A/B/C.
- Synchronises and debounces the Hall sensor inputs, then maps the Hall code to a six-step (120°) commutation pattern.
- Ramp-limits the commanded duty cycle and drives each phase's duty_cycle and high_z inputs.
- Detects invalid Hall codes and rotor stall, and forces the bridge to high impedance on either fault.

Parameters:
- DUTY_CYCLE_WIDTH, 10: width of duty command and per-phase duty outputs.
- HALL_FILTER_CYCLES, 4: consecutive identical synchronised samples required to accept a new Hall code; legal range 1..15.
- RAMP_DIV, 64: clocks between ramp steps; legal values ≥1.
- RAMP_STEP, 4: duty increment/decrement per ramp step.
- STALL_TIMEOUT, 'hFFFFF: clocks without a Hall edge, while driving non-zero duty, before stall is flagged.
- STALL_WIDTH, 20: width of the stall counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Reset is synchronous and active-low.
- en  in  1  run enable; low = idle, clears faults and ramp.
- reverse  in  1  direction select; 0 = forward.
- brake  in  1  low-side brake request.
- duty_cycle_cmd  in  DUTY_CYCLE_WIDTH  target duty.
- hall  in  3  raw asynchronous Hall inputs {C,B,A}.
- duty_a, duty_b, duty_c  out  DUTY_CYCLE_WIDTH  per-phase duty to Phase_Driver.
- high_z_a, high_z_b, high_z_c  out  1  per-phase float request.
- hall_fault  out  1  sticky invalid-Hall flag.
- stall  out  1  sticky stall flag.
- duty_applied  out  DUTY_CYCLE_WIDTH  current ramped duty.

Behaviour:
- Reset values (rst_n low at a clk edge):
  - state = IDLE.
  - All high_z outputs = 1.
  - All duty outputs = 0; duty_applied = 0.
  - hall_fault = 0; stall = 0.
  - Filter cleared; hall_valid = 0.
  - Stall counter = 0.
- Hall synchroniser and filter:
  - Two-flop synchroniser on each Hall bit.
  - Filter holds a candidate value and a run count. A new filtered code is accepted once the synchronised value has equalled the candidate for HALL_FILTER_CYCLES consecutive clocks.
  - hall_valid is set on the first acceptance after reset or after en rises.
  - Total latency from a stable Hall pin change to a commutated output change is exactly HALL_FILTER_CYCLES+3 clocks.
  - Glitches shorter than HALL_FILTER_CYCLES clocks never change the outputs.
- Forward commutation table (filtered code CBA -> high phase / low phase / floating phase):
  - 101 -> A / B / C
  - 100 -> A / C / B
  - 110 -> B / C / A
  - 010 -> B / A / C
  - 011 -> C / A / B
  - 001 -> C / B / A
  - reverse=1 swaps the high and low phase in every entry.
- Phase outputs in RUN:
  - High phase: duty = duty_applied, high_z = 0.
  - Low phase: duty = 0, high_z = 0 (Phase_Driver holds its low side on).
  - Floating phase: duty = 0, high_z = 1.
- State machine: IDLE, RUN, BRAKE, FAULT. Transitions are evaluated every clock with priority en low > fault > brake > run.
  - IDLE: all phases high_z = 1, duty 0; hall_fault, stall and duty_applied cleared. Go to RUN or BRAKE when en = 1 and hall_valid.
  - RUN: table-driven outputs. Go to BRAKE when brake = 1. Go to FAULT on any fault.
  - BRAKE: all phases high_z = 0, duty 0; duty_applied forced to 0. Return to RUN when brake = 0.
  - FAULT: all phases high_z = 1, duty 0. Exit only via en = 0 (to IDLE).
- Faults:
  - hall_fault sets when hall_valid and the filtered code is 000 or 111.
  - stall sets when the stall counter reaches STALL_TIMEOUT.
  - Both flags are sticky and clear only in IDLE.
- Ramp:
  - A divider counts RAMP_DIV clocks. On each tick in RUN, duty_applied moves toward duty_cycle_cmd by RAMP_STEP.
  - duty_applied saturates at the target: no overshoot, no wrap.
  - The divider resets when entering RUN.
  - A toggle of reverse while in RUN forces duty_applied to 0 on the next clock, after which it re-ramps.
- Stall counter:
  - Increments in RUN while duty_applied != 0.
  - Clears on every accepted filtered-code change, on duty_applied = 0, and in any state other than RUN.
  - Saturates at STALL_TIMEOUT.
- Outputs are registered and change one clock after the state or table input changes.
- rst_n asserted mid-operation returns all outputs to reset values on that edge.

Test Plan:
- Reset, en=1, hall=101 held stable, duty_cycle_cmd=200 -> high_z_c=1, duty_a ramps 0,4,8,… every 64 clocks, settles at 200 exactly; duty_b=duty_c=0.
- Step hall through the forward sequence 101,100,110,010,011,001 -> each output change occurs 7 clocks after the pin change (HALL_FILTER_CYCLES=4); a 3-clock glitch to 111 produces no change and no hall_fault.
- reverse toggled 0->1 while in RUN at hall=101 -> duty_applied=0 next clock; then duty_b ramps with A low.
- Hall held at 111 for ≥4 clocks while en=1 -> hall_fault=1, all high_z=1. Returning hall to a valid code keeps the fault set; en pulsed low clears it.
- brake=1 during RUN -> all high_z=0, all duties 0, duty_applied=0. brake=0 -> re-ramp from 0.
- STALL_TIMEOUT=100, duty non-zero, hall frozen -> stall=1 on the 100th clock of RUN with non-zero duty, state FAULT. rst_n low mid-ramp -> all outputs at reset values on that edge.

Source files
------------

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation controller: Hall synchroniser/filter, ramped duty command,
// stall and invalid-Hall protection, driving three Phase_Driver instances.
module bldc_commutator #(
  parameter int unsigned DUTY_CYCLE_WIDTH   = 10,
  parameter int unsigned HALL_FILTER_CYCLES = 4,
  parameter int unsigned RAMP_DIV           = 64,
  parameter int unsigned RAMP_STEP          = 4,
  parameter int unsigned STALL_TIMEOUT      = 'hFFFFF,
  parameter int unsigned STALL_WIDTH        = 20
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        reverse,
  input  logic                        brake,
  input  logic [DUTY_CYCLE_WIDTH-1:0] duty_cycle_cmd,
  input  logic [2:0]                  hall,
  output logic [DUTY_CYCLE_WIDTH-1:0] duty_a,
  output logic [DUTY_CYCLE_WIDTH-1:0] duty_b,
  output logic [DUTY_CYCLE_WIDTH-1:0] duty_c,
  output logic                        high_z_a,
  output logic                        high_z_b,
  output logic                        high_z_c,
  output logic                        hall_fault,
  output logic                        stall,
  output logic [DUTY_CYCLE_WIDTH-1:0] duty_applied
);
  localparam int unsigned DW         = DUTY_CYCLE_WIDTH;
  localparam int unsigned DivW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned DivLastInt = RAMP_DIV - 1;
  localparam logic [DivW-1:0]        DivLast  = DivLastInt[DivW-1:0];
  localparam logic [3:0]             FiltN    = HALL_FILTER_CYCLES[3:0];
  localparam logic [DW:0]            StepExt  = RAMP_STEP[DW:0];
  localparam logic [STALL_WIDTH-1:0] StallMax = STALL_TIMEOUT[STALL_WIDTH-1:0];

  typedef enum logic [1:0] {StIdle, StRun, StBrake, StFault} state_e;
  state_e state_q, state_d;

  logic [2:0]             hall_s1_q, hall_s2_q, cand_q, filt_q, filt_d;
  logic [1:0]             fill_q, fill_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   hall_valid_q, hall_valid_d, accept, code_chg, hall_bad;
  logic                   rev_q, tick;
  logic [DivW-1:0]        div_q, div_d;
  logic [DW-1:0]          duty_applied_q, duty_applied_d;
  logic [DW:0]            app_ext, cmd_ext;
  logic [STALL_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic                   hall_fault_q, hall_fault_d, stall_q, stall_d;
  logic [2:0]             hi, lo, ph_hi, ph_lo, hz_d, hz_q;
  logic [DW-1:0]          da_d, db_d, dc_d, da_q, db_q, dc_q;

  // Filter waits for the synchroniser to fill after reset so stale zeros are never accepted.
  always_comb begin
    fill_d = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    cnt_d  = cnt_q;
    if (fill_q == 2'd2) begin
      if (hall_s2_q != cand_q) cnt_d = 4'd1;
      else if (cnt_q != FiltN) cnt_d = cnt_q + 4'd1;
    end
    accept       = (fill_q == 2'd2) && (cnt_d == FiltN);
    filt_d       = accept ? hall_s2_q : filt_q;
    code_chg     = accept && (hall_s2_q != filt_q);
    hall_valid_d = en && (hall_valid_q || accept);
    hall_bad     = hall_valid_q && ((filt_q == 3'b000) || (filt_q == 3'b111));
  end

  always_comb begin
    app_ext        = {1'b0, duty_applied_q};
    cmd_ext        = {1'b0, duty_cycle_cmd};
    tick           = (state_q == StRun) && (div_q == DivLast);
    div_d          = ((state_q != StRun) || tick) ? '0 : div_q + DivW'(1);
    duty_applied_d = duty_applied_q;
    if (state_q != StRun) begin
      duty_applied_d = '0;
    end else if (reverse != rev_q) begin
      duty_applied_d = '0;
    end else if (tick) begin
      if (cmd_ext > app_ext) begin
        duty_applied_d = ((cmd_ext - app_ext) <= StepExt) ? duty_cycle_cmd
                                                          : duty_applied_q + StepExt[DW-1:0];
      end else if (app_ext > cmd_ext) begin
        duty_applied_d = ((app_ext - cmd_ext) <= StepExt) ? duty_cycle_cmd
                                                          : duty_applied_q - StepExt[DW-1:0];
      end
    end

    stall_cnt_d = '0;
    if ((state_q == StRun) && (duty_applied_q != '0) && !code_chg) begin
      stall_cnt_d = (stall_cnt_q == StallMax) ? stall_cnt_q : stall_cnt_q + STALL_WIDTH'(1);
    end
    hall_fault_d = (state_q != StIdle) && (hall_fault_q || hall_bad);
    stall_d      = (state_q != StIdle) && (stall_q || (stall_cnt_d == StallMax));
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (hall_valid_q) state_d = brake ? StBrake : StRun;
        StRun: begin
          if (hall_fault_d || stall_d) state_d = StFault;
          else if (brake)              state_d = StBrake;
        end
        StBrake: begin
          if (hall_fault_d || stall_d) state_d = StFault;
          else if (!brake)             state_d = StRun;
        end
        StFault: state_d = StFault;
        default: state_d = StIdle;
      endcase
    end
  end

  // Phase masks are one-hot {C,B,A}; reverse swaps the driven-high and held-low phases.
  always_comb begin
    case (filt_q)
      3'b101:  begin hi = 3'b001; lo = 3'b010; end
      3'b100:  begin hi = 3'b001; lo = 3'b100; end
      3'b110:  begin hi = 3'b010; lo = 3'b100; end
      3'b010:  begin hi = 3'b010; lo = 3'b001; end
      3'b011:  begin hi = 3'b100; lo = 3'b001; end
      3'b001:  begin hi = 3'b100; lo = 3'b010; end
      default: begin hi = 3'b000; lo = 3'b000; end
    endcase
    ph_hi = rev_q ? lo : hi;
    ph_lo = rev_q ? hi : lo;
    hz_d  = 3'b111;
    da_d  = '0;
    db_d  = '0;
    dc_d  = '0;
    case (state_q)
      StRun: begin
        hz_d = ~(ph_hi | ph_lo);
        da_d = ph_hi[0] ? duty_applied_q : '0;
        db_d = ph_hi[1] ? duty_applied_q : '0;
        dc_d = ph_hi[2] ? duty_applied_q : '0;
      end
      StBrake: hz_d = 3'b000;
      default: hz_d = 3'b111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      hall_s1_q      <= '0;
      hall_s2_q      <= '0;
      cand_q         <= '0;
      filt_q         <= '0;
      fill_q         <= '0;
      cnt_q          <= '0;
      hall_valid_q   <= 1'b0;
      rev_q          <= 1'b0;
      div_q          <= '0;
      duty_applied_q <= '0;
      stall_cnt_q    <= '0;
      hall_fault_q   <= 1'b0;
      stall_q        <= 1'b0;
      hz_q           <= 3'b111;
      da_q           <= '0;
      db_q           <= '0;
      dc_q           <= '0;
    end else begin
      state_q        <= state_d;
      hall_s1_q      <= hall;
      hall_s2_q      <= hall_s1_q;
      cand_q         <= hall_s2_q;
      filt_q         <= filt_d;
      fill_q         <= fill_d;
      cnt_q          <= cnt_d;
      hall_valid_q   <= hall_valid_d;
      rev_q          <= reverse;
      div_q          <= div_d;
      duty_applied_q <= duty_applied_d;
      stall_cnt_q    <= stall_cnt_d;
      hall_fault_q   <= hall_fault_d;
      stall_q        <= stall_d;
      hz_q           <= hz_d;
      da_q           <= da_d;
      db_q           <= db_d;
      dc_q           <= dc_d;
    end
  end

  assign duty_a       = da_q;
  assign duty_b       = db_q;
  assign duty_c       = dc_q;
  assign high_z_a     = hz_q[0];
  assign high_z_b     = hz_q[1];
  assign high_z_c     = hz_q[2];
  assign hall_fault   = hall_fault_q;
  assign stall        = stall_q;
  assign duty_applied = duty_applied_q;
endmodule

// File: tb/tb_bldc_commutator.sv
// Scoreboard bench: stimulus pushes timestamped expected output snapshots, monitors pop one
// per observed output change and compare both the cycle and the values.
module tb_bldc_commutator;
  typedef struct packed {
    logic [9:0] da;
    logic [9:0] db;
    logic [9:0] dc;
    logic [2:0] hz;  // {c,b,a}
    logic       hf;
    logic       st;
    logic [9:0] dap;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic s_done = 1'b0;

  // Main DUT (default stall timeout) and a short-timeout DUT for the stall check.
  logic       m_rst_n, m_en, m_rev, m_brk;
  logic [9:0] m_cmd, m_da, m_db, m_dc, m_dap;
  logic [2:0] m_hall;
  logic       m_hza, m_hzb, m_hzc, m_hf, m_st;
  logic       s_rst_n, s_en, s_rev, s_brk;
  logic [9:0] s_cmd, s_da, s_db, s_dc, s_dap;
  logic [2:0] s_hall;
  logic       s_hza, s_hzb, s_hzc, s_hf, s_st;

  bldc_commutator u_main (
    .clk(clk), .rst_n(m_rst_n), .en(m_en), .reverse(m_rev), .brake(m_brk),
    .duty_cycle_cmd(m_cmd), .hall(m_hall), .duty_a(m_da), .duty_b(m_db), .duty_c(m_dc),
    .high_z_a(m_hza), .high_z_b(m_hzb), .high_z_c(m_hzc), .hall_fault(m_hf), .stall(m_st),
    .duty_applied(m_dap)
  );

  bldc_commutator #(.STALL_TIMEOUT(100)) u_stall (
    .clk(clk), .rst_n(s_rst_n), .en(s_en), .reverse(s_rev), .brake(s_brk),
    .duty_cycle_cmd(s_cmd), .hall(s_hall), .duty_a(s_da), .duty_b(s_db), .duty_c(s_dc),
    .high_z_a(s_hza), .high_z_b(s_hzb), .high_z_c(s_hzc), .hall_fault(s_hf), .stall(s_st),
    .duty_applied(s_dap)
  );

  obs_t m_obs, s_obs, m_model, s_model;
  obs_t m_prev = 'x;
  obs_t s_prev = 'x;
  exp_t m_q[$];
  exp_t s_q[$];
  assign m_obs = {m_da, m_db, m_dc, m_hzc, m_hzb, m_hza, m_hf, m_st, m_dap};
  assign s_obs = {s_da, s_db, s_dc, s_hzc, s_hzb, s_hza, s_hf, s_st, s_dap};

  logic [2:0] seq_code [5] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
  logic [2:0] seq_hz   [5] = '{3'b010, 3'b001, 3'b100, 3'b010, 3'b001};
  int         seq_hi   [5] = '{0, 1, 1, 2, 2};
  int         rr       [3] = '{4, 8, 10};

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic m_exp(input int c);
    exp_t e;
    e.cyc = c;
    e.v   = m_model;
    m_q.push_back(e);
  endtask

  task automatic s_exp(input int c);
    exp_t e;
    e.cyc = c;
    e.v   = s_model;
    s_q.push_back(e);
  endtask

  function automatic void compare(input string tag, input exp_t e, input int c, input obs_t g);
    checks++;
    if ((e.cyc != c) || (g !== e.v)) begin
      errors++;
      $display("FAIL %s: cycle %0d got da=%0d db=%0d dc=%0d hz=%b hf=%b st=%b dap=%0d; required cycle %0d da=%0d db=%0d dc=%0d hz=%b hf=%b st=%b dap=%0d",
               tag, c, g.da, g.db, g.dc, g.hz, g.hf, g.st, g.dap,
               e.cyc, e.v.da, e.v.db, e.v.dc, e.v.hz, e.v.hf, e.v.st, e.v.dap);
    end
  endfunction

  always @(negedge clk) begin
    if (m_obs !== m_prev) begin
      if (m_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL main_unexpected: cycle %0d got change to %h; required no change", cyc, m_obs);
      end else begin
        compare("main", m_q.pop_front(), cyc, m_obs);
      end
      m_prev <= m_obs;
    end
  end

  always @(negedge clk) begin
    if (s_obs !== s_prev) begin
      if (s_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stall_unexpected: cycle %0d got change to %h; required no change", cyc, s_obs);
      end else begin
        compare("stall", s_q.pop_front(), cyc, s_obs);
      end
      s_prev <= s_obs;
    end
  end

  // Stall DUT: hall frozen at 101, duty first non-zero at cycle 73, stall 100 clocks later.
  initial begin
    s_rst_n = 1'b0; s_en = 1'b0; s_rev = 1'b0; s_brk = 1'b0; s_cmd = '0; s_hall = '0;
    s_model = '0; s_model.hz = 3'b111; s_exp(1);
    s_model.hz = 3'b100; s_exp(10);
    s_model.dap = 10'd4; s_exp(73);
    s_model.da  = 10'd4; s_exp(74);
    s_model.dap = 10'd8; s_exp(137);
    s_model.da  = 10'd8; s_exp(138);
    s_model.st  = 1'b1;  s_exp(173);
    s_model.da = '0; s_model.dap = '0; s_model.hz = 3'b111; s_exp(174);
    wait_cyc(2);
    s_rst_n = 1'b1; s_en = 1'b1; s_hall = 3'b101; s_cmd = 10'd200;
    wait_cyc(220);
    s_done = 1'b1;
  end

  initial begin
    m_rst_n = 1'b0; m_en = 1'b0; m_rev = 1'b0; m_brk = 1'b0; m_cmd = '0; m_hall = '0;
    m_model = '0; m_model.hz = 3'b111; m_exp(1);

    // Start-up and ramp 0 -> 200 in steps of 4 every 64 clocks.
    wait_cyc(2);
    m_rst_n = 1'b1; m_en = 1'b1; m_hall = 3'b101; m_cmd = 10'd200;
    m_model.hz = 3'b100; m_exp(10);
    for (int k = 1; k <= 50; k++) begin
      m_model.dap = 10'(4 * k); m_exp(9 + 64 * k);
      m_model.da  = 10'(4 * k); m_exp(10 + 64 * k);
    end

    // Forward Hall sequence: each output change 7 clocks after the pin change.
    for (int i = 0; i < 5; i++) begin
      wait_cyc(3220 + 10 * i);
      m_hall = seq_code[i];
      m_model.da = (seq_hi[i] == 0) ? 10'd200 : 10'd0;
      m_model.db = (seq_hi[i] == 1) ? 10'd200 : 10'd0;
      m_model.dc = (seq_hi[i] == 2) ? 10'd200 : 10'd0;
      m_model.hz = seq_hz[i];
      m_exp(3227 + 10 * i);
    end
    wait_cyc(3280); m_hall = 3'b111;
    wait_cyc(3283); m_hall = 3'b001;
    wait_cyc(3300); m_hall = 3'b101;
    m_model.da = 10'd200; m_model.dc = '0; m_model.hz = 3'b100; m_exp(3307);

    // Reverse toggle zeroes the ramp; B now driven high, A low.
    wait_cyc(3320); m_rev = 1'b1; m_cmd = 10'd12;
    m_model.dap = '0; m_exp(3321);
    m_model.da  = '0; m_exp(3322);
    for (int k = 1; k <= 3; k++) begin
      m_model.dap = 10'(4 * k); m_exp(3273 + 64 * k);
      m_model.db  = 10'(4 * k); m_exp(3274 + 64 * k);
    end
    wait_cyc(3480); m_cmd = 10'd10;
    m_model.dap = 10'd10; m_exp(3529);
    m_model.db  = 10'd10; m_exp(3530);

    // Brake and release.
    wait_cyc(3540); m_brk = 1'b1;
    m_model.dap = '0; m_model.db = '0; m_model.hz = 3'b000; m_exp(3542);
    wait_cyc(3560); m_brk = 1'b0;
    m_model.hz = 3'b100; m_exp(3562);
    for (int k = 0; k < 3; k++) begin
      m_model.dap = 10'(rr[k]); m_exp(3625 + 64 * k);
      m_model.db  = 10'(rr[k]); m_exp(3626 + 64 * k);
    end

    // Invalid Hall code: sticky fault until en is pulsed low.
    wait_cyc(3770); m_hall = 3'b111;
    m_model.hz = 3'b111; m_model.db = '0; m_model.hf = 1'b1; m_exp(3777);
    m_model.dap = '0; m_exp(3778);
    wait_cyc(3790); m_hall = 3'b101;
    wait_cyc(3810); m_en = 1'b0;
    m_model.hf = 1'b0; m_exp(3812);
    wait_cyc(3815); m_en = 1'b1;
    m_model.hz = 3'b100; m_exp(3818);
    m_model.dap = 10'd4; m_exp(3881);
    m_model.db  = 10'd4; m_exp(3882);

    // Reset mid-ramp.
    wait_cyc(3900); m_rst_n = 1'b0;
    m_model = '0; m_model.hz = 3'b111; m_exp(3901);

    wait_cyc(3920);
    checks++;
    if (m_q.size() != 0) begin
      errors++;
      $display("FAIL main_pending: got %0d events never observed; required 0", m_q.size());
    end
    checks++;
    if (!s_done || s_q.size() != 0) begin
      errors++;
      $display("FAIL stall_pending: got %0d events never observed; required 0", s_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
